// File: rtl/apb_usrt_ctrl.sv
// APB-slave USRT controller: programmable bit clock, TX/RX FIFOs, optional parity,
// sticky error flags and a level interrupt.
module apb_usrt_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        pSelect,
    input  logic        pEnable,
    input  logic        pWrite,
    input  logic [1:0]  pAddress,
    input  logic [15:0] pWData,
    output logic [15:0] pRData,
    output logic        pReady,
    output logic        Tx,
    input  logic        Rx,
    output logic        uClk,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} txState_t;
    typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rxState_t;

    logic [4:0]  ctrl;
    logic [15:0] divReg, halfDiv, baudCnt;
    logic        rxOverrun, parityErr, frameErr, txDrop;
    logic        en, parEn, parOdd, rxIe, errIe, enD;
    logic        wr, rd, tick, riseTick, fallTick;

    assign wr     = pSelect & pEnable & pWrite;
    assign rd     = pSelect & pEnable & ~pWrite;
    assign en     = ctrl[0];
    assign parEn  = ctrl[1];
    assign parOdd = ctrl[2];
    assign rxIe   = ctrl[3];
    assign errIe  = ctrl[4];
    // Disabling takes effect on the CTRL write edge so Tx/uClk are idle from the next cycle.
    assign enD    = (wr && pAddress == 2'd2) ? pWData[0] : en;
    assign pReady = 1'b1;

    assign tick     = enD && (baudCnt == halfDiv);
    assign riseTick = tick & ~uClk;
    assign fallTick = tick & uClk;

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            baudCnt <= '0;
            uClk    <= 1'b0;
            halfDiv <= '0;
        end else if (!enD) begin
            baudCnt <= '0;
            uClk    <= 1'b0;
            halfDiv <= divReg;
        end else if (tick) begin
            baudCnt <= '0;
            uClk    <= ~uClk;
            halfDiv <= divReg;
        end else begin
            baudCnt <= baudCnt + 16'd1;
        end
    end

    // TX FIFO
    logic [DATA_W-1:0] txMem [FIFO_DEPTH];
    logic [PW-1:0]     txWp, txRp;
    logic              txEmpty, txFull, txPushReq, txPush, txPop;
    logic [DATA_W-1:0] txHead;
    txState_t          txState;

    assign txEmpty   = (txWp == txRp);
    assign txFull    = (txWp[AW] != txRp[AW]) && (txWp[AW-1:0] == txRp[AW-1:0]);
    assign txHead    = txMem[txRp[AW-1:0]];
    assign txPushReq = wr && (pAddress == 2'd0);
    assign txPop     = fallTick && (txState == TxIdle || txState == TxStop) && !txEmpty;
    assign txPush    = txPushReq && (!txFull || txPop);

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            txWp <= '0;
            txRp <= '0;
        end else begin
            if (txPush) txWp <= txWp + 1'b1;
            if (txPop)  txRp <= txRp + 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (txPush) txMem[txWp[AW-1:0]] <= pWData[DATA_W-1:0];
    end

    // TX FSM
    logic [DATA_W-1:0] txShift;
    logic              txPar;
    logic [CW-1:0]     txCnt;

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            txState <= TxIdle;
            Tx      <= 1'b1;
            txShift <= '0;
            txPar   <= 1'b0;
            txCnt   <= '0;
        end else if (!enD) begin
            txState <= TxIdle;
            Tx      <= 1'b1;
        end else if (fallTick) begin
            case (txState)
                TxIdle, TxStop: begin
                    if (!txEmpty) begin
                        txShift <= txHead;
                        txPar   <= ^txHead;
                        Tx      <= 1'b0;
                        txState <= TxStart;
                    end else begin
                        Tx      <= 1'b1;
                        txState <= TxIdle;
                    end
                end
                TxStart: begin
                    Tx      <= txShift[0];
                    txShift <= txShift >> 1;
                    txCnt   <= '0;
                    txState <= TxData;
                end
                TxData: begin
                    if (txCnt == CW'(DATA_W - 1)) begin
                        if (parEn) begin
                            Tx      <= txPar ^ parOdd;
                            txState <= TxParity;
                        end else begin
                            Tx      <= 1'b1;
                            txState <= TxStop;
                        end
                    end else begin
                        Tx      <= txShift[0];
                        txShift <= txShift >> 1;
                        txCnt   <= txCnt + 1'b1;
                    end
                end
                TxParity: begin
                    Tx      <= 1'b1;
                    txState <= TxStop;
                end
                default: begin
                    Tx      <= 1'b1;
                    txState <= TxIdle;
                end
            endcase
        end
    end

    // RX FSM
    rxState_t          rxState;
    logic [DATA_W-1:0] rxShift;
    logic [CW-1:0]     rxCnt;
    logic              rxParErr, rxStopTick, rxPushReq, frameSet, paritySet;

    assign rxStopTick = riseTick && (rxState == RxStop);
    assign rxPushReq  = rxStopTick && Rx && !rxParErr;
    assign frameSet   = rxStopTick && !Rx;
    assign paritySet  = rxStopTick && rxParErr;

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            rxState  <= RxIdle;
            rxShift  <= '0;
            rxCnt    <= '0;
            rxParErr <= 1'b0;
        end else if (!enD) begin
            rxState <= RxIdle;
        end else if (riseTick) begin
            case (rxState)
                RxIdle: begin
                    if (!Rx) begin
                        rxState  <= RxData;
                        rxCnt    <= '0;
                        rxParErr <= 1'b0;
                    end
                end
                RxData: begin
                    rxShift <= {Rx, rxShift[DATA_W-1:1]};
                    if (rxCnt == CW'(DATA_W - 1)) rxState <= parEn ? RxParity : RxStop;
                    else rxCnt <= rxCnt + 1'b1;
                end
                RxParity: begin
                    rxParErr <= (^rxShift) ^ Rx ^ parOdd;
                    rxState  <= RxStop;
                end
                default: rxState <= RxIdle;
            endcase
        end
    end

    // RX FIFO
    logic [DATA_W-1:0] rxMem [FIFO_DEPTH];
    logic [PW-1:0]     rxWp, rxRp;
    logic              rxEmpty, rxFull, rxPush, rxPop, overrunSet;
    logic [DATA_W-1:0] rxHead;

    assign rxEmpty    = (rxWp == rxRp);
    assign rxFull     = (rxWp[AW] != rxRp[AW]) && (rxWp[AW-1:0] == rxRp[AW-1:0]);
    assign rxHead     = rxMem[rxRp[AW-1:0]];
    assign rxPop      = rd && (pAddress == 2'd0) && !rxEmpty;
    assign rxPush     = rxPushReq && (!rxFull || rxPop);
    assign overrunSet = rxPushReq && rxFull && !rxPop;

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            rxWp <= '0;
            rxRp <= '0;
        end else begin
            if (rxPush) rxWp <= rxWp + 1'b1;
            if (rxPop)  rxRp <= rxRp + 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (rxPush) rxMem[rxWp[AW-1:0]] <= rxShift;
    end

    // Registers and sticky flags; a set on the same edge as a clear wins.
    logic statusClr;
    assign statusClr = wr && (pAddress == 2'd1);

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            ctrl      <= '0;
            divReg    <= '0;
            rxOverrun <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            txDrop    <= 1'b0;
        end else begin
            if (wr && pAddress == 2'd2) ctrl   <= pWData[4:0];
            if (wr && pAddress == 2'd3) divReg <= pWData;
            rxOverrun <= overrunSet | (rxOverrun & ~(statusClr & pWData[4]));
            parityErr <= paritySet | (parityErr & ~(statusClr & pWData[5]));
            frameErr  <= frameSet | (frameErr & ~(statusClr & pWData[6]));
            txDrop    <= (txPushReq & ~txPush) | (txDrop & ~(statusClr & pWData[8]));
        end
    end

    logic txBusy;
    assign txBusy = (txState != TxIdle);
    assign irq = (rxIe & ~rxEmpty) | (errIe & (rxOverrun | parityErr | frameErr | txDrop));

    always_comb begin
        pRData = '0;
        if (pSelect && !pWrite) begin
            case (pAddress)
                2'd0: if (!rxEmpty) pRData = 16'(rxHead);
                2'd1: pRData = {7'b0, txDrop, txBusy, frameErr, parityErr, rxOverrun,
                                rxFull, rxEmpty, txFull, txEmpty};
                2'd2: pRData = {11'b0, ctrl};
                default: pRData = divReg;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_usrt_ctrl.sv
// Directed bench for apb_usrt_ctrl: TX bit stream and RX words checked against scoreboard queues.
module tb_apb_usrt_ctrl;
    localparam int DW = 8;

    logic        pClk = 1'b0;
    logic        pReset = 1'b1;
    logic        pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
    logic [1:0]  pAddress = 2'd0;
    logic [15:0] pWData = 16'd0;
    logic [15:0] pRData;
    logic        pReady, Tx, uClk, irq;
    logic        loopback = 1'b0, rxDrive = 1'b1, rxLine;

    int nAsserts = 0;
    int nFail = 0;

    logic        expQ[$];
    logic [15:0] rxQ[$];
    logic [15:0] rd;

    assign rxLine = loopback ? Tx : rxDrive;

    apb_usrt_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
        .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
        .pReady(pReady), .Tx(Tx), .Rx(rxLine), .uClk(uClk), .irq(irq)
    );

    always #5 pClk = ~pClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apbWrite(input logic [1:0] a, input logic [15:0] d);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = a; pWData = d;
        @(negedge pClk);
        pEnable = 1'b1;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apbRead(input logic [1:0] a, output logic [15:0] d);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = a;
        @(negedge pClk);
        pEnable = 1'b1;
        #1 d = pRData;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] v;
        apbRead(a, v);
        check(tag, v, exp);
    endtask

    task automatic doReset();
        loopback = 1'b0; rxDrive = 1'b1;
        @(negedge pClk);
        pReset = 1'b1;
        repeat (2) @(negedge pClk);
        pReset = 1'b0;
    endtask

    task automatic pushFrame(input logic [15:0] w, input bit pe, input bit po);
        expQ.push_back(1'b0);
        for (int i = 0; i < DW; i++) expQ.push_back(w[i]);
        if (pe) expQ.push_back((^w[DW-1:0]) ^ po);
        expQ.push_back(1'b1);
    endtask

    task automatic waitTxLow(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge pClk);
            if (Tx === 1'b0) break;
        end
        check({tag, " start"}, Tx, 0);
    endtask

    // Bits last 4 pClk (DIV=1); sample each one mid-bit, with no gaps between frames.
    task automatic checkFrames(input string tag);
        bit   first;
        logic b;
        first = 1'b1;
        waitTxLow(tag);
        repeat (2) @(negedge pClk);
        while (expQ.size() > 0) begin
            if (!first) repeat (4) @(negedge pClk);
            first = 1'b0;
            b = expQ.pop_front();
            check(tag, Tx, b);
        end
    endtask

    task automatic driveRxBit(input logic b);
        rxDrive = b;
        repeat (4) @(negedge pClk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge pClk);
        check("reset Tx", Tx, 1);
        check("reset uClk", uClk, 0);
        check("reset irq", irq, 0);
        check("reset pRData", pRData, 0);
        check("pReady", pReady, 1);
        pReset = 1'b0;
        checkReg("reset STATUS", 2'd1, 16'h0005);
        checkReg("reset CTRL", 2'd2, 16'h0000);
        checkReg("reset DIV", 2'd3, 16'h0000);

        // Basic TX
        apbWrite(2'd3, 16'd1);
        checkReg("DIV readback", 2'd3, 16'h0001);
        apbWrite(2'd2, 16'h0001);
        apbWrite(2'd0, 16'h00A5);
        pushFrame(16'h00A5, 1'b0, 1'b0);
        checkFrames("basic tx bit");
        repeat (8) @(negedge pClk);
        checkReg("basic tx idle STATUS", 2'd1, 16'h0005);

        // Parity and loopback
        doReset();
        apbWrite(2'd3, 16'd1);
        loopback = 1'b1;
        apbWrite(2'd2, 16'h0003);
        apbWrite(2'd0, 16'h00A5);
        pushFrame(16'h00A5, 1'b1, 1'b0);
        rxQ.push_back(16'h00A5);
        checkFrames("parity tx bit");
        repeat (8) @(negedge pClk);
        checkReg("loopback STATUS", 2'd1, 16'h0001);
        apbRead(2'd0, rd);
        check("loopback data", rd, rxQ.pop_front());
        checkReg("loopback empty STATUS", 2'd1, 16'h0005);
        checkReg("empty DATA read", 2'd0, 16'h0000);

        // TX FIFO boundary
        doReset();
        apbWrite(2'd3, 16'd1);
        for (int i = 1; i <= 5; i++) begin
            apbWrite(2'd0, 16'(i * 'h11));
            if (i <= 4) pushFrame(16'(i * 'h11), 1'b0, 1'b0);
        end
        checkReg("tx full STATUS", 2'd1, 16'h0106);
        apbWrite(2'd2, 16'h0001);
        checkFrames("b2b tx bit");
        repeat (8) @(negedge pClk);
        checkReg("b2b done STATUS", 2'd1, 16'h0105);
        apbWrite(2'd1, 16'h0100);
        checkReg("tx_drop clear", 2'd1, 16'h0005);

        // RX frame error
        doReset();
        apbWrite(2'd3, 16'd1);
        apbWrite(2'd2, 16'h0011);
        repeat (3) @(negedge pClk);
        driveRxBit(1'b0);
        for (int i = 0; i < DW; i++) driveRxBit(i[0]);
        driveRxBit(1'b0);
        rxDrive = 1'b1;
        repeat (8) @(negedge pClk);
        checkReg("frame_err STATUS", 2'd1, 16'h0045);
        check("frame_err irq", irq, 1);
        apbWrite(2'd1, 16'h0040);
        checkReg("frame_err clear", 2'd1, 16'h0005);
        check("irq cleared", irq, 0);

        // Overrun
        doReset();
        apbWrite(2'd3, 16'd1);
        loopback = 1'b1;
        apbWrite(2'd2, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            apbWrite(2'd0, 16'(8'h30 + i));
            rxQ.push_back(16'(8'h30 + i));
        end
        repeat (40) @(negedge pClk);
        apbWrite(2'd0, 16'h0099);
        repeat (300) @(negedge pClk);
        checkReg("overrun STATUS", 2'd1, 16'h0019);
        while (rxQ.size() > 0) begin
            apbRead(2'd0, rd);
            check("overrun data", rd, rxQ.pop_front());
        end
        checkReg("overrun drained STATUS", 2'd1, 16'h0015);

        // Disable mid-frame
        doReset();
        apbWrite(2'd3, 16'd1);
        loopback = 1'b1;
        apbWrite(2'd2, 16'h0001);
        apbWrite(2'd0, 16'h0000);
        waitTxLow("disable");
        repeat (15) @(negedge pClk);
        check("pre-disable Tx", Tx, 0);
        apbWrite(2'd2, 16'h0000);
        check("disable Tx", Tx, 1);
        check("disable uClk", uClk, 0);
        repeat (40) @(negedge pClk);
        checkReg("disable STATUS", 2'd1, 16'h0005);

        // Reset mid-frame
        doReset();
        apbWrite(2'd3, 16'd1);
        loopback = 1'b1;
        apbWrite(2'd2, 16'h0009);
        apbWrite(2'd0, 16'h003C);
        repeat (60) @(negedge pClk);
        check("rx irq", irq, 1);
        apbWrite(2'd0, 16'h0000);
        waitTxLow("reset");
        repeat (10) @(negedge pClk);
        pReset = 1'b1;
        #1;
        check("mid reset Tx", Tx, 1);
        check("mid reset uClk", uClk, 0);
        check("mid reset irq", irq, 0);
        check("mid reset pRData", pRData, 0);
        @(negedge pClk);
        pReset = 1'b0;
        checkReg("post reset STATUS", 2'd1, 16'h0005);
        checkReg("post reset CTRL", 2'd2, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
